// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder
//   Target-side IEEE 1149.1 TAP controller for the simulation JTAG link.
//   Everything runs in the system clock domain. The JTAG pins are
//   oversampled through synchronizer chains, and TCK edges are detected from
//   the synchronized TCK. Implements IDCODE, BYPASS and one USER data
//   register with a capture/update handshake for a debug-module front end.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   jtag_TCK/TMS/TDI     JTAG pins from the host (asynchronous to clock)
//   jtag_TRSTn           active-low TAP reset pin
//   jtag_TDO_data        serial data out, updated on TCK fall
//   jtag_TDO_driven      1 while TDO_data is valid (Shift-IR / Shift-DR)
//   user_capture_data    value loaded into the USER DR at Capture-DR
//   user_capture_strobe  one-clock pulse when the USER DR captures
//   user_update_valid    one-clock pulse at Update-DR with USER selected
//   user_update_data     last shifted-in USER value, held between updates
//   tap_state            current TAP state encoding
//   ir_value             active instruction
module jtag_tap_responder #(
  parameter int                  IR_WIDTH    = 5,
  parameter logic [31:0]         IDCODE_VAL  = 32'h20000913,
  parameter logic [IR_WIDTH-1:0] USER_IR     = 5'h10,
  parameter int                  USER_WIDTH  = 32,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  jtag_TCK,
  input  logic                  jtag_TMS,
  input  logic                  jtag_TDI,
  input  logic                  jtag_TRSTn,
  output logic                  jtag_TDO_data,
  output logic                  jtag_TDO_driven,
  input  logic [USER_WIDTH-1:0] user_capture_data,
  output logic                  user_capture_strobe,
  output logic                  user_update_valid,
  output logic [USER_WIDTH-1:0] user_update_data,
  output logic [3:0]            tap_state,
  output logic [IR_WIDTH-1:0]   ir_value
);

  typedef enum logic [3:0] {
    TAP_TLR   = 4'hF, TAP_RTI   = 4'hC,
    TAP_SELDR = 4'h7, TAP_CAPDR = 4'h6, TAP_SHDR  = 4'h2, TAP_EX1DR = 4'h1,
    TAP_PAUDR = 4'h3, TAP_EX2DR = 4'h0, TAP_UPDDR = 4'h5,
    TAP_SELIR = 4'h4, TAP_CAPIR = 4'hE, TAP_SHIR  = 4'hA, TAP_EX1IR = 4'h9,
    TAP_PAUIR = 4'hB, TAP_EX2IR = 4'h8, TAP_UPDIR = 4'hD
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

  // ---- pin synchronizers ----
  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync, trstn_sync;
  logic                   tck_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      tck_sync   <= '0;
      tms_sync   <= '0;
      tdi_sync   <= '0;
      trstn_sync <= '0;
      tck_prev   <= 1'b0;
    end else begin
      tck_sync   <= {tck_sync[SYNC_STAGES-2:0], jtag_TCK};
      tms_sync   <= {tms_sync[SYNC_STAGES-2:0], jtag_TMS};
      tdi_sync   <= {tdi_sync[SYNC_STAGES-2:0], jtag_TDI};
      trstn_sync <= {trstn_sync[SYNC_STAGES-2:0], jtag_TRSTn};
      tck_prev   <= tck_sync[SYNC_STAGES-1];
    end
  end

  logic tck_s, tms_s, tdi_s, trstn_s, tck_rise, tck_fall;
  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign trstn_s  = trstn_sync[SYNC_STAGES-1];
  // Rise and fall are mutually exclusive: both come from one synchronized bit.
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;

  // ---- TAP next state ----
  tap_state_t state, next_state;

  always_comb begin
    next_state = state;
    unique case (state)
      TAP_TLR:   next_state = tms_s ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   next_state = tms_s ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: next_state = tms_s ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: next_state = tms_s ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  next_state = tms_s ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: next_state = tms_s ? TAP_UPDDR : TAP_PAUDR;
      TAP_PAUDR: next_state = tms_s ? TAP_EX2DR : TAP_PAUDR;
      TAP_EX2DR: next_state = tms_s ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR: next_state = tms_s ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: next_state = tms_s ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: next_state = tms_s ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  next_state = tms_s ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: next_state = tms_s ? TAP_UPDIR : TAP_PAUIR;
      TAP_PAUIR: next_state = tms_s ? TAP_EX2IR : TAP_PAUIR;
      TAP_EX2IR: next_state = tms_s ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR: next_state = tms_s ? TAP_SELDR : TAP_RTI;
      default:   next_state = TAP_TLR;
    endcase
  end

  // ---- data registers and instruction decode ----
  logic [IR_WIDTH-1:0]   ir_shift;
  logic [31:0]           idcode_shift;
  logic                  bypass_reg;
  logic [USER_WIDTH-1:0] user_shift;
  logic                  sel_idcode, sel_user, dr_lsb;

  // IDCODE wins should USER_IR ever be set to the IDCODE opcode.
  assign sel_idcode = (ir_value == IR_IDCODE);
  assign sel_user   = !sel_idcode && (ir_value == USER_IR);
  assign dr_lsb     = sel_idcode ? idcode_shift[0] :
                      sel_user   ? user_shift[0]   : bypass_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= TAP_TLR;
      ir_value            <= IR_IDCODE;
      ir_shift            <= '0;
      idcode_shift        <= '0;
      bypass_reg          <= 1'b0;
      user_shift          <= '0;
      jtag_TDO_data       <= 1'b0;
      jtag_TDO_driven     <= 1'b0;
      user_capture_strobe <= 1'b0;
      user_update_valid   <= 1'b0;
      user_update_data    <= '0;
    end else begin
      user_capture_strobe <= 1'b0;
      user_update_valid   <= 1'b0;
      if (!trstn_s) begin
        // TRSTn overrides any coincident TCK edge and suppresses strobes.
        state           <= TAP_TLR;
        ir_value        <= IR_IDCODE;
        jtag_TDO_driven <= 1'b0;
      end else begin
        if (state == TAP_TLR) ir_value <= IR_IDCODE;
        if (tck_rise) begin
          state <= next_state;
          if (next_state == TAP_TLR) ir_value <= IR_IDCODE;
          case (state)
            TAP_CAPIR: ir_shift <= IR_WIDTH'(2'b01);
            TAP_SHIR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
            TAP_CAPDR: begin
              if (sel_idcode) begin
                idcode_shift <= IDCODE_VAL;
              end else if (sel_user) begin
                user_shift          <= user_capture_data;
                user_capture_strobe <= 1'b1;
              end else begin
                bypass_reg <= 1'b0;
              end
            end
            TAP_SHDR: begin
              if (sel_idcode) begin
                idcode_shift <= {tdi_s, idcode_shift[31:1]};
              end else if (sel_user) begin
                // Written as shift/or so a 1-bit USER DR needs no special case.
                user_shift <= (user_shift >> 1) |
                              (USER_WIDTH'(tdi_s) << (USER_WIDTH - 1));
              end else begin
                bypass_reg <= tdi_s;
              end
            end
            default: ;
          endcase
        end else if (tck_fall) begin
          jtag_TDO_driven <= 1'b0;
          case (state)
            TAP_SHIR: begin
              jtag_TDO_data   <= ir_shift[0];
              jtag_TDO_driven <= 1'b1;
            end
            TAP_SHDR: begin
              jtag_TDO_data   <= dr_lsb;
              jtag_TDO_driven <= 1'b1;
            end
            TAP_UPDIR: ir_value <= ir_shift;
            TAP_UPDDR: begin
              if (sel_user) begin
                user_update_data  <= user_shift;
                user_update_valid <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign tap_state = state;

endmodule

// File: tb/tb_jtag_tap_responder.sv
module tb_jtag_tap_responder;

  localparam int          IR_W   = 5;
  localparam int          UW     = 32;
  localparam int          SYNC   = 2;
  localparam int          H      = 5;   // clocks per TCK phase
  localparam logic [31:0] IDCODE = 32'h20000913;
  localparam logic [4:0]  USERIR = 5'h10;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                         S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUDR = 4'h3, S_EX2DR = 4'h0,
                         S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                         S_EX1IR = 4'h9, S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
  logic            jtag_TDO_data, jtag_TDO_driven;
  logic [UW-1:0]   user_capture_data = '0;
  logic            user_capture_strobe, user_update_valid;
  logic [UW-1:0]   user_update_data;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] ir_value;

  jtag_tap_responder #(
    .IR_WIDTH(IR_W), .IDCODE_VAL(IDCODE), .USER_IR(USERIR),
    .USER_WIDTH(UW), .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .user_capture_data(user_capture_data), .user_capture_strobe(user_capture_strobe),
    .user_update_valid(user_update_valid), .user_update_data(user_update_data),
    .tap_state(tap_state), .ir_value(ir_value)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int cap_cnt = 0, upd_cnt = 0;
  logic [UW-1:0] upd_seen = '0;

  // Count handshake pulses; each pulse is one clock wide, so it is seen once.
  always @(posedge clock) begin
    if (user_capture_strobe) cap_cnt++;
    if (user_update_valid) begin
      upd_cnt++;
      upd_seen = user_update_data;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Standard 1149.1 state graph.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      S_TLR:   return tms ? S_TLR   : S_RTI;
      S_RTI:   return tms ? S_SELDR : S_RTI;
      S_SELDR: return tms ? S_SELIR : S_CAPDR;
      S_CAPDR: return tms ? S_EX1DR : S_SHDR;
      S_SHDR:  return tms ? S_EX1DR : S_SHDR;
      S_EX1DR: return tms ? S_UPDDR : S_PAUDR;
      S_PAUDR: return tms ? S_EX2DR : S_PAUDR;
      S_EX2DR: return tms ? S_UPDDR : S_SHDR;
      S_UPDDR: return tms ? S_SELDR : S_RTI;
      S_SELIR: return tms ? S_TLR   : S_CAPIR;
      S_CAPIR: return tms ? S_EX1IR : S_SHIR;
      S_SHIR:  return tms ? S_EX1IR : S_SHIR;
      S_EX1IR: return tms ? S_UPDIR : S_PAUIR;
      S_PAUIR: return tms ? S_EX2IR : S_PAUIR;
      S_EX2IR: return tms ? S_UPDIR : S_SHIR;
      default: return tms ? S_SELDR : S_RTI;
    endcase
  endfunction

  logic [3:0]  m_state = S_TLR;
  logic [63:0] sh_in, sh_out;
  int          sh_pos;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One full TCK period; TDO is sampled after the falling edge.
  task automatic tick(input logic tms, input logic tdi, output logic tdo);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    wait_clk(H);
    jtag_TCK = 1'b1;
    wait_clk(H);
    jtag_TCK = 1'b0;
    wait_clk(H);
    m_state = tap_next(m_state, tms);
    check("tap_state", tap_state, m_state);
    check("tdo_driven", jtag_TDO_driven, (m_state == S_SHDR) || (m_state == S_SHIR));
    tdo = jtag_TDO_data;
  endtask

  task automatic tk(input logic tms);
    logic b;
    tick(tms, 1'b0, b);
  endtask

  // Move from Capture/Exit2 into Shift; the first out bit appears here.
  task automatic enter_shift();
    logic b;
    tick(1'b0, 1'b0, b);
    sh_out[sh_pos] = b;
  endtask

  task automatic shift_n(input int n, input logic do_exit);
    logic b, last;
    for (int k = 0; k < n; k++) begin
      last = do_exit && (k == n - 1);
      tick(last, sh_in[sh_pos], b);
      sh_pos++;
      if (!last) sh_out[sh_pos] = b;
    end
  endtask

  // From RTI: load an instruction and return to RTI.
  task automatic ir_scan(input logic [4:0] op);
    tk(1); tk(1); tk(0);
    sh_in = {59'b0, op}; sh_out = '0; sh_pos = 0;
    enter_shift();
    shift_n(5, 1'b1);
    check("ir_capture", sh_out[4:0], 5'b00001);
    tk(1);
    check("ir_value", ir_value, op);
    tk(0);
  endtask

  // From RTI: DR scan of n bits, through Update-DR, back to RTI.
  task automatic dr_scan(input int n, input logic [63:0] din);
    tk(1); tk(0);
    sh_in = din; sh_out = '0; sh_pos = 0;
    enter_shift();
    shift_n(n, 1'b1);
    tk(1); tk(0);
  endtask

  initial begin
    int c0, u0, n, w;
    logic [4:0]   op;
    logic [31:0]  cap, cap_exp;
    logic [63:0]  din, mask;
    logic [127:0] comb;

    // Reset state
    wait_clk(3);
    check("rst_state", tap_state, S_TLR);
    check("rst_ir", ir_value, 5'd1);
    check("rst_tdo", jtag_TDO_data, 1'b0);
    check("rst_driven", jtag_TDO_driven, 1'b0);
    check("rst_upd_data", user_update_data, '0);
    check("rst_upd_valid", user_update_valid, 1'b0);
    check("rst_cap_strobe", user_capture_strobe, 1'b0);
    reset = 1'b0;
    wait_clk(4);

    // Test 1: stay in TLR
    for (int i = 0; i < 5; i++) begin
      tk(1);
      check("tlr_ir", ir_value, 5'd1);
    end

    // Random TMS walk, then back to TLR (which must restore IDCODE)
    for (int i = 0; i < 40; i++) tk($urandom_range(0, 1));
    for (int i = 0; i < 5; i++) tk(1);
    check("walk_tlr_ir", ir_value, 5'd1);
    tk(0);

    // Test 2: IDCODE readout
    c0 = cap_cnt; u0 = upd_cnt;
    dr_scan(32, 64'd0);
    check("idcode_tdo", sh_out[31:0], IDCODE);
    check("idcode_no_cap", cap_cnt - c0, 0);
    check("idcode_no_upd", upd_cnt - u0, 0);

    // Test 3: all-ones instruction selects BYPASS (1-TCK delay)
    ir_scan(5'h1F);
    dr_scan(4, 64'b1101);
    check("bypass_tdo", sh_out[3:0], 4'b1010);

    // Test 4: USER capture / update
    ir_scan(USERIR);
    user_capture_data = 32'hDEADBEEF;
    c0 = cap_cnt; u0 = upd_cnt;
    dr_scan(32, 64'h12345678);
    check("user_tdo", sh_out[31:0], 32'hDEADBEEF);
    check("user_cap_cnt", cap_cnt - c0, 1);
    check("user_upd_cnt", upd_cnt - u0, 1);
    check("user_upd_pulse_data", upd_seen, 32'h12345678);
    check("user_upd_hold", user_update_data, 32'h12345678);

    // Test 5: paused scan resumes without recapture
    cap = $urandom; user_capture_data = cap;
    din = {32'b0, $urandom};
    c0 = cap_cnt; u0 = upd_cnt;
    tk(1); tk(0);
    sh_in = din; sh_out = '0; sh_pos = 0;
    enter_shift();
    shift_n(16, 1'b1);
    tk(0);
    for (int i = 0; i < 10; i++) tk(0);
    tk(1);
    enter_shift();
    shift_n(16, 1'b1);
    tk(1); tk(0);
    check("pause_tdo", sh_out[31:0], cap);
    check("pause_cap_cnt", cap_cnt - c0, 1);
    check("pause_upd_cnt", upd_cnt - u0, 1);
    check("pause_upd_data", user_update_data, din[31:0]);

    // Randomized instruction / DR scans against the scan model
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0:       op = 5'd1;
        1:       op = USERIR;
        default: op = 5'($urandom);
      endcase
      ir_scan(op);
      cap = $urandom; user_capture_data = cap;
      n = $urandom_range(1, 40);
      mask = (64'd1 << n) - 64'd1;
      din = {$urandom, $urandom} & mask;
      if (op == 5'd1)        begin w = 32; cap_exp = IDCODE; end
      else if (op == USERIR) begin w = 32; cap_exp = cap;    end
      else                   begin w = 1;  cap_exp = 32'd0;  end
      c0 = cap_cnt; u0 = upd_cnt;
      dr_scan(n, din);
      // Out stream = captured register contents followed by the shifted-in bits.
      comb = ({64'b0, din} << w) | {96'b0, cap_exp};
      check("rnd_tdo", sh_out & mask, comb[63:0] & mask);
      if (op == USERIR) begin
        check("rnd_cap_cnt", cap_cnt - c0, 1);
        check("rnd_upd_cnt", upd_cnt - u0, 1);
        comb = comb >> n;
        check("rnd_upd_data", upd_seen, comb[31:0]);
      end else begin
        check("rnd_cap_cnt", cap_cnt - c0, 0);
        check("rnd_upd_cnt", upd_cnt - u0, 0);
      end
    end

    // Test 6a: TRSTn during the 10th USER shift bit
    ir_scan(USERIR);
    user_capture_data = 32'hA5A5_0F0F;
    din = {32'b0, $urandom};
    u0 = upd_cnt;
    tk(1); tk(0);
    sh_in = din; sh_out = '0; sh_pos = 0;
    enter_shift();
    shift_n(9, 1'b0);
    jtag_TDI = 1'b1;
    wait_clk(H);
    jtag_TCK = 1'b1;
    wait_clk(1);
    jtag_TRSTn = 1'b0;
    wait_clk(SYNC + 2);
    check("trst_state", tap_state, S_TLR);
    check("trst_ir", ir_value, 5'd1);
    check("trst_driven", jtag_TDO_driven, 1'b0);
    jtag_TCK = 1'b0;
    jtag_TMS = 1'b1;
    wait_clk(H);
    jtag_TRSTn = 1'b1;
    wait_clk(H);
    m_state = S_TLR;
    check("trst_state_after", tap_state, S_TLR);
    check("trst_no_upd", upd_cnt - u0, 0);
    check("trst_upd_hold", user_update_data, din[31:0] ^ din[31:0] ^ upd_seen);
    tk(0);

    // Test 6b: system reset during the 10th USER shift bit
    ir_scan(USERIR);
    u0 = upd_cnt;
    tk(1); tk(0);
    sh_in = din; sh_out = '0; sh_pos = 0;
    enter_shift();
    shift_n(9, 1'b0);
    jtag_TDI = 1'b1;
    jtag_TMS = 1'b0;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    check("rst_mid_state", tap_state, S_TLR);
    check("rst_mid_ir", ir_value, 5'd1);
    check("rst_mid_driven", jtag_TDO_driven, 1'b0);
    wait_clk(SYNC + 2);
    check("rst_mid_state_after", tap_state, S_TLR);
    check("rst_mid_upd_data", user_update_data, '0);
    check("rst_mid_no_upd", upd_cnt - u0, 0);
    m_state = S_TLR;
    tk(1);
    tk(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
